rob_operand_responder: RTL and testbench

// - ROB-side responder of the operand-lookup protocol used at issue: allocates ROB tags, captures Arith/LS CDB results per tag, answers Q1/Q2 ready+value queries.
// - Retires the oldest ready entry in order, with a registered commit pulse toward the regfile and commit logic.
// - Tag 0 (`ZERO_ROB) means "no dependency". Valid tags are 1..ROB_SIZE, allocated circularly.

---
 rtl/rob_operand_responder_if.sv | 58 +++++
 rtl/rob_operand_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_rob_operand_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_operand_responder_if.sv
// Operand-lookup bus between issue/dispatch/CDB and the ROB responder.
// Ports: rdy, flush, alloc req/grant, full/empty, two CDBs, Q1/Q2 query, commit.
interface rob_operand_responder_if #(
  parameter int ID_W   = 5,
  parameter int DATA_W = 32
);
  logic              rdy;
  logic              flush;

  logic              alloc_valid;
  logic [ID_W-1:0]   alloc_rob_id;
  logic              full;
  logic              empty;

  logic              valid_from_Arith_unit_cdb;
  logic [ID_W-1:0]   rob_id_from_Arith_unit_cdb;
  logic [DATA_W-1:0] result_from_Arith_unit_cdb;
  logic              valid_from_LS_unit_cdb;
  logic [ID_W-1:0]   rob_id_from_LS_unit_cdb;
  logic [DATA_W-1:0] result_from_LS_unit_cdb;

  logic [ID_W-1:0]   Q1_query;
  logic [ID_W-1:0]   Q2_query;
  logic              Q1_ready_from_rob;
  logic              Q2_ready_from_rob;
  logic [DATA_W-1:0] V1_result_from_rob;
  logic [DATA_W-1:0] V2_result_from_rob;

  logic              commit_valid;
  logic [ID_W-1:0]   commit_rob_id;
  logic [DATA_W-1:0] commit_value;

  modport master (
    output rdy, flush, alloc_valid,
    output valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
    output result_from_Arith_unit_cdb,
    output valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
    output result_from_LS_unit_cdb,
    output Q1_query, Q2_query,
    input  alloc_rob_id, full, empty,
    input  Q1_ready_from_rob, Q2_ready_from_rob,
    input  V1_result_from_rob, V2_result_from_rob,
    input  commit_valid, commit_rob_id, commit_value
  );

  modport slave (
    input  rdy, flush, alloc_valid,
    input  valid_from_Arith_unit_cdb, rob_id_from_Arith_unit_cdb,
    input  result_from_Arith_unit_cdb,
    input  valid_from_LS_unit_cdb, rob_id_from_LS_unit_cdb,
    input  result_from_LS_unit_cdb,
    input  Q1_query, Q2_query,
    output alloc_rob_id, full, empty,
    output Q1_ready_from_rob, Q2_ready_from_rob,
    output V1_result_from_rob, V2_result_from_rob,
    output commit_valid, commit_rob_id, commit_value
  );
endinterface

// File: rtl/rob_operand_responder.sv
// ROB-side operand responder: allocates tags 1..ROB_SIZE, captures CDB
// results, answers Q1/Q2 lookups and retires the head in order.
// Ports: clk, rst (async, active-high), bus (rob_operand_responder_if.slave).
// Option: define ROB_QUERY_BYPASS_EN to let queries see same-cycle CDB data.
module rob_operand_responder #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W     = 5,
  parameter int DATA_W   = 32
) (
  input logic                   clk,
  input logic                   rst,
  rob_operand_responder_if.slave bus
);

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam id_t FIRST = id_t'(1);
  localparam id_t LAST  = id_t'(ROB_SIZE);

  logic [ROB_SIZE:1] busy_q, busy_d;
  logic [ROB_SIZE:1] ready_q, ready_d;
  data_t             value_q [ROB_SIZE:1];
  data_t             value_d [ROB_SIZE:1];

  id_t   head_q, head_d;
  id_t   tail_q, tail_d;
  id_t   count_q, count_d;
  logic  full_q, full_d;
  logic  empty_q, empty_d;

  logic  commit_valid_q, commit_valid_d;
  id_t   commit_rob_id_q, commit_rob_id_d;
  data_t commit_value_q, commit_value_d;

  logic  a_vld, l_vld;
  id_t   a_id, l_id;
  data_t a_res, l_res;

  assign a_vld = bus.valid_from_Arith_unit_cdb;
  assign a_id  = bus.rob_id_from_Arith_unit_cdb;
  assign a_res = bus.result_from_Arith_unit_cdb;
  assign l_vld = bus.valid_from_LS_unit_cdb;
  assign l_id  = bus.rob_id_from_LS_unit_cdb;
  assign l_res = bus.result_from_LS_unit_cdb;

  function automatic id_t wrap_inc(id_t p);
    return (p == LAST) ? FIRST : p + FIRST;
  endfunction

  // Head entry readiness and value
  logic  head_ready;
  data_t head_value;

  always_comb begin
    head_ready = 1'b0;
    head_value = '0;
    for (int i = 1; i <= ROB_SIZE; i++) begin
      if (head_q == id_t'(i)) begin
        head_ready = ready_q[i];
        head_value = value_q[i];
      end
    end
  end

  logic do_alloc;
  logic do_commit;

  // full is the registered pre-edge view, so an alloc while full is
  // refused even when the same edge retires an entry.
  assign do_alloc  = bus.alloc_valid && !full_q && !bus.flush;
  assign do_commit = !empty_q && head_ready && !bus.flush;

  always_comb begin
    busy_d          = busy_q;
    ready_d         = ready_q;
    value_d         = value_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    commit_valid_d  = 1'b0;
    commit_rob_id_d = commit_rob_id_q;
    commit_value_d  = commit_value_q;

    if (bus.rdy) begin
      if (bus.flush) begin
        busy_d  = '0;
        ready_d = '0;
        for (int i = 1; i <= ROB_SIZE; i++) begin
          value_d[i] = '0;
        end
        head_d          = FIRST;
        tail_d          = FIRST;
        count_d         = '0;
        commit_rob_id_d = '0;
        commit_value_d  = '0;
      end else begin
        // CDB capture; Arith wins when both hit the same tag
        for (int i = 1; i <= ROB_SIZE; i++) begin
          if (busy_q[i]) begin
            if (a_vld && a_id == id_t'(i)) begin
              ready_d[i] = 1'b1;
              value_d[i] = a_res;
            end else if (l_vld && l_id == id_t'(i)) begin
              ready_d[i] = 1'b1;
              value_d[i] = l_res;
            end
          end
        end

        if (do_commit) begin
          commit_valid_d  = 1'b1;
          commit_rob_id_d = head_q;
          commit_value_d  = head_value;
          for (int i = 1; i <= ROB_SIZE; i++) begin
            if (head_q == id_t'(i)) begin
              busy_d[i]  = 1'b0;
              ready_d[i] = 1'b0;
              value_d[i] = '0;
            end
          end
          head_d = wrap_inc(head_q);
        end

        // tail can only equal head here when the ROB is empty, so the
        // alloc never collides with the retiring entry.
        if (do_alloc) begin
          for (int i = 1; i <= ROB_SIZE; i++) begin
            if (tail_q == id_t'(i)) begin
              busy_d[i]  = 1'b1;
              ready_d[i] = 1'b0;
              value_d[i] = '0;
            end
          end
          tail_d = wrap_inc(tail_q);
        end

        count_d = count_q + id_t'(do_alloc) - id_t'(do_commit);
      end
    end
  end

  assign full_d  = (count_d == LAST);
  assign empty_d = (count_d == '0);

  // Query lookup: {ready, value}
  function automatic logic [DATA_W:0] lookup(id_t q);
    logic  r;
    data_t v;
    r = 1'b0;
    v = '0;
    for (int i = 1; i <= ROB_SIZE; i++) begin
      if (q == id_t'(i) && busy_q[i] && ready_q[i]) begin
        r = 1'b1;
        v = value_q[i];
      end
    end
`ifdef ROB_QUERY_BYPASS_EN
    // Same-cycle CDB data overrides, mirroring what the edge will store
    for (int i = 1; i <= ROB_SIZE; i++) begin
      if (q == id_t'(i) && busy_q[i] && bus.rdy && !bus.flush) begin
        if (a_vld && a_id == q) begin
          r = 1'b1;
          v = a_res;
        end else if (l_vld && l_id == q) begin
          r = 1'b1;
          v = l_res;
        end
      end
    end
`endif
    return {r, v};
  endfunction

  logic [DATA_W:0] q1_res;
  logic [DATA_W:0] q2_res;

  always_comb begin
    q1_res = lookup(bus.Q1_query);
    q2_res = lookup(bus.Q2_query);
  end

  assign bus.Q1_ready_from_rob  = q1_res[DATA_W];
  assign bus.V1_result_from_rob = q1_res[DATA_W-1:0];
  assign bus.Q2_ready_from_rob  = q2_res[DATA_W];
  assign bus.V2_result_from_rob = q2_res[DATA_W-1:0];

  assign bus.alloc_rob_id  = tail_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.commit_value  = commit_value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      for (int i = 1; i <= ROB_SIZE; i++) begin
        value_q[i] <= '0;
      end
      head_q          <= FIRST;
      tail_q          <= FIRST;
      count_q         <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      commit_valid_q  <= 1'b0;
      commit_rob_id_q <= '0;
      commit_value_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      for (int i = 1; i <= ROB_SIZE; i++) begin
        value_q[i] <= value_d[i];
      end
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      commit_valid_q  <= commit_valid_d;
      commit_rob_id_q <= commit_rob_id_d;
      commit_value_q  <= commit_value_d;
    end
  end

endmodule

// File: tb/tb_rob_operand_responder.sv
// Self-checking bench for rob_operand_responder.
// Commits are checked against a queue of expected {tag, value} pairs.
module tb_rob_operand_responder;

  localparam int ROB_SIZE = 16;
  localparam int ID_W     = 5;
  localparam int DATA_W   = 32;

  logic clk;
  logic rst;

  rob_operand_responder_if #(.ID_W(ID_W), .DATA_W(DATA_W)) bus ();

  rob_operand_responder #(
    .ROB_SIZE(ROB_SIZE),
    .ID_W(ID_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_a(logic v, int id, logic [DATA_W-1:0] r);
    bus.valid_from_Arith_unit_cdb  = v;
    bus.rob_id_from_Arith_unit_cdb = ID_W'(id);
    bus.result_from_Arith_unit_cdb = r;
  endtask

  task automatic cdb_l(logic v, int id, logic [DATA_W-1:0] r);
    bus.valid_from_LS_unit_cdb  = v;
    bus.rob_id_from_LS_unit_cdb = ID_W'(id);
    bus.result_from_LS_unit_cdb = r;
  endtask

  // Commit monitor: every retire must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && bus.commit_valid) begin
        if (exp_q.size() == 0) begin
          chk("commit_extra", 64'(bus.commit_rob_id), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("commit_id", 64'(bus.commit_rob_id), 64'(e.id));
          chk("commit_val", 64'(bus.commit_value), 64'(e.val));
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.rdy     = 1'b1;
    bus.flush   = 1'b0;
    bus.alloc_valid = 1'b0;
    bus.Q1_query = '0;
    bus.Q2_query = '0;
    cdb_a(1'b0, 0, '0);
    cdb_l(1'b0, 0, '0);
    tick();
    tick();

    // Reset state
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_commit", 64'(bus.commit_valid), 64'd0);
    chk("rst_tail", 64'(bus.alloc_rob_id), 64'd1);
    chk("rst_q1", 64'(bus.Q1_ready_from_rob), 64'd0);
    rst = 1'b0;
    tick();

    // Fill: tags 1..16
    for (int i = 1; i <= ROB_SIZE; i++) begin
      bus.alloc_valid = 1'b1;
      #1;
      chk("alloc_id", 64'(bus.alloc_rob_id), 64'(i));
      tick();
    end
    chk("full_after16", 64'(bus.full), 64'd1);
    chk("empty_after16", 64'(bus.empty), 64'd0);
    #1;
    chk("tail_wrap", 64'(bus.alloc_rob_id), 64'd1);
    tick();
    chk("refuse17_tail", 64'(bus.alloc_rob_id), 64'd1);
    chk("refuse17_full", 64'(bus.full), 64'd1);
    bus.alloc_valid = 1'b0;

    // Both CDBs hit tag 2: Arith wins
    cdb_a(1'b1, 2, 32'h11);
    cdb_l(1'b1, 2, 32'h22);
    bus.Q1_query = ID_W'(2);
    #1;
`ifdef ROB_QUERY_BYPASS_EN
    chk("t2_same_rdy", 64'(bus.Q1_ready_from_rob), 64'd1);
`else
    chk("t2_same_rdy", 64'(bus.Q1_ready_from_rob), 64'd0);
`endif
    tick();
    cdb_a(1'b0, 0, '0);
    cdb_l(1'b0, 0, '0);
    #1;
    chk("t2_rdy", 64'(bus.Q1_ready_from_rob), 64'd1);
    chk("t2_val", 64'(bus.V1_result_from_rob), 64'h11);

    // Head 1 not ready: no retire even though tag 2 is ready
    tick();
    chk("hold_c0", 64'(bus.commit_valid), 64'd0);
    tick();
    chk("hold_c1", 64'(bus.commit_valid), 64'd0);

    // Tag 1 result arrives -> retire 1 then 2
    cdb_a(1'b1, 1, 32'h5);
    exp_q.push_back('{id: ID_W'(1), val: 32'h5});
    exp_q.push_back('{id: ID_W'(2), val: 32'h11});
    tick();
    cdb_a(1'b0, 0, '0);
    // Alloc while full in the commit cycle: refused
    bus.alloc_valid = 1'b1;
    tick();
    chk("c1_valid", 64'(bus.commit_valid), 64'd1);
    chk("c1_id", 64'(bus.commit_rob_id), 64'd1);
    chk("full_refuse_tail", 64'(bus.alloc_rob_id), 64'd1);
    chk("full_after_c1", 64'(bus.full), 64'd0);
    // Now alloc accepted while tag 2 retires: count unchanged
    tick();
    chk("c2_valid", 64'(bus.commit_valid), 64'd1);
    chk("c2_id", 64'(bus.commit_rob_id), 64'd2);
    chk("alloc_c2_tail", 64'(bus.alloc_rob_id), 64'd2);
    chk("alloc_c2_full", 64'(bus.full), 64'd0);
    tick();
    bus.alloc_valid = 1'b0;
    chk("refill_full", 64'(bus.full), 64'd1);
    chk("refill_tail", 64'(bus.alloc_rob_id), 64'd3);

    // Tag 3 DEADBEEF, queried on Q1 and Q2
    cdb_a(1'b1, 3, 32'hDEADBEEF);
    exp_q.push_back('{id: ID_W'(3), val: 32'hDEADBEEF});
    bus.Q1_query = ID_W'(3);
    bus.Q2_query = ID_W'(3);
    #1;
`ifndef ROB_QUERY_BYPASS_EN
    chk("t3_same_rdy", 64'(bus.Q1_ready_from_rob), 64'd0);
    chk("t3_same_val", 64'(bus.V1_result_from_rob), 64'd0);
`endif
    tick();
    cdb_a(1'b0, 0, '0);
    #1;
    chk("t3_q1_rdy", 64'(bus.Q1_ready_from_rob), 64'd1);
    chk("t3_q1_val", 64'(bus.V1_result_from_rob), 64'hDEADBEEF);
    chk("t3_q2_val", 64'(bus.V2_result_from_rob), 64'hDEADBEEF);
    tick();
    chk("c3_valid", 64'(bus.commit_valid), 64'd1);
    chk("t3_cleared", 64'(bus.Q1_ready_from_rob), 64'd0);
    chk("c3_full", 64'(bus.full), 64'd0);

    // rdy low: nothing moves
    bus.rdy = 1'b0;
    bus.alloc_valid = 1'b1;
    cdb_a(1'b1, 4, 32'h44);
    bus.Q1_query = ID_W'(4);
    tick();
    chk("rdy0_commit", 64'(bus.commit_valid), 64'd0);
    tick();
    chk("rdy0_tail", 64'(bus.alloc_rob_id), 64'd3);
    chk("rdy0_q1", 64'(bus.Q1_ready_from_rob), 64'd0);
    chk("rdy0_full", 64'(bus.full), 64'd0);
    bus.rdy = 1'b1;
    bus.alloc_valid = 1'b0;
    cdb_a(1'b0, 0, '0);

    // Flush
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("fl_empty", 64'(bus.empty), 64'd1);
    chk("fl_full", 64'(bus.full), 64'd0);
    chk("fl_tail", 64'(bus.alloc_rob_id), 64'd1);
    chk("fl_commit", 64'(bus.commit_valid), 64'd0);

    // CDB to idle tag 9 is ignored; tag 0 query is never ready
    cdb_a(1'b1, 9, 32'h99);
    bus.Q1_query = ID_W'(9);
    bus.Q2_query = '0;
    tick();
    cdb_a(1'b0, 0, '0);
    #1;
    chk("idle9_rdy", 64'(bus.Q1_ready_from_rob), 64'd0);
    chk("idle9_val", 64'(bus.V1_result_from_rob), 64'd0);
    chk("q0_rdy", 64'(bus.Q2_ready_from_rob), 64'd0);

    // Alloc after flush returns tag 1; LS write to tag 0 ignored
    bus.alloc_valid = 1'b1;
    #1;
    chk("post_fl_id", 64'(bus.alloc_rob_id), 64'd1);
    tick();
    bus.alloc_valid = 1'b0;
    cdb_l(1'b1, 0, 32'hAA);
    bus.Q1_query = ID_W'(1);
    tick();
    cdb_l(1'b0, 0, '0);
    #1;
    chk("tag0_ignored", 64'(bus.Q1_ready_from_rob), 64'd0);

    // Reset in the middle of a commit pulse
    cdb_a(1'b1, 1, 32'h77);
    exp_q.push_back('{id: ID_W'(1), val: 32'h77});
    tick();
    cdb_a(1'b0, 0, '0);
    tick();
    chk("pre_rst_commit", 64'(bus.commit_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_commit", 64'(bus.commit_valid), 64'd0);
    chk("rst_mid_empty", 64'(bus.empty), 64'd1);
    chk("rst_mid_tail", 64'(bus.alloc_rob_id), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
